// File: rtl/dmem_access_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage (port 0) and the loader/debug port (port 1).
// Each access holds mem_en for ACCESS_CYCLES cycles. A one-cycle done phase follows before the next grant.
//
// state  | meaning
// IDLE   | no owner; arbitrate on any request
// ACCESS | mem_en held, cnt counts up to ACCESS_CYCLES-1
// DONE   | done pulse to owner; last-winner updated
module dmem_access_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int ACCESS_CYCLES = 6,
    parameter int FIXED_PRI     = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_done,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_done,
    output logic [DW-1:0] rdata,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic [1:0]      gnt_q, gnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            pick1;

    // On a tie, round-robin hands the port to whichever did not win last.
    always_comb begin
        pick1 = 1'b0;
        if (r0_req && r1_req) begin
            pick1 = (FIXED_PRI != 0) ? 1'b0 : ~last_q;
        end else begin
            pick1 = r1_req;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    we_d    = pick1 ? r1_we    : r0_we;
                    addr_d  = pick1 ? r1_addr  : r0_addr;
                    wdata_d = pick1 ? r1_wdata : r0_wdata;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                last_d  = gnt_q[1];
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    assign mem_en    = (state_q == S_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign gnt       = gnt_q;
    assign busy      = (state_q != S_IDLE);
    assign r0_done   = (state_q == S_DONE) & gnt_q[0];
    assign r1_done   = (state_q == S_DONE) & gnt_q[1];

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: a round-robin and a fixed-priority instance share one set of inputs.
// Each instance is checked every cycle against a timestamp-based model of its grants.
module tb_dmem_access_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int AC = 6;

    logic          clk;
    logic          reset;
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] mem_rdata;

    logic          o_d0    [2];
    logic          o_d1    [2];
    logic [DW-1:0] o_rdata [2];
    logic [1:0]    o_gnt   [2];
    logic          o_busy  [2];
    logic          o_en    [2];
    logic          o_we    [2];
    logic [AW-1:0] o_addr  [2];
    logic [DW-1:0] o_wdata [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // model: instance 0 = round-robin, 1 = fixed priority
    int            m_start [2];
    int            m_free  [2];
    int            m_owner [2];
    logic          m_last  [2];
    logic          m_we    [2];
    logic [AW-1:0] m_addr  [2];
    logic [DW-1:0] m_wdata [2];
    logic [DW-1:0] m_rdata [2];

    dmem_access_arbiter #(.AW(AW), .DW(DW), .ACCESS_CYCLES(AC), .FIXED_PRI(0)) u_rr (
        .clk(clk), .reset(reset),
        .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]), .r0_done(o_d0[0]),
        .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]), .r1_done(o_d1[0]),
        .rdata(o_rdata[0]), .gnt(o_gnt[0]), .busy(o_busy[0]), .mem_en(o_en[0]), .mem_we(o_we[0]),
        .mem_addr(o_addr[0]), .mem_wdata(o_wdata[0]), .mem_rdata(mem_rdata)
    );

    dmem_access_arbiter #(.AW(AW), .DW(DW), .ACCESS_CYCLES(AC), .FIXED_PRI(1)) u_fx (
        .clk(clk), .reset(reset),
        .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]), .r0_done(o_d0[1]),
        .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]), .r1_done(o_d1[1]),
        .rdata(o_rdata[1]), .gnt(o_gnt[1]), .busy(o_busy[1]), .mem_en(o_en[1]), .mem_we(o_we[1]),
        .mem_addr(o_addr[1]), .mem_wdata(o_wdata[1]), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_start[i] = -1000;
            m_free[i]  = 0;
            m_owner[i] = 0;
            m_last[i]  = 1'b1;
            m_we[i]    = 1'b0;
            m_addr[i]  = '0;
            m_wdata[i] = '0;
            m_rdata[i] = '0;
        end
    endtask

    // An access granted at edge e owns the port for periods e..e+AC (last one is the done period);
    // the port is free to grant again at edge e+AC+2.
    task automatic model_edge(input int i, input int e);
        int w;
        if (e == m_start[i] + AC && !m_we[i]) m_rdata[i] = mem_rdata;
        if (e == m_start[i] + AC + 1) m_last[i] = (m_owner[i] == 1);
        if (e >= m_free[i] && (req[0] || req[1])) begin
            if (req[0] && req[1]) w = (i == 1) ? 0 : (m_last[i] ? 0 : 1);
            else                  w = req[1] ? 1 : 0;
            m_owner[i] = w;
            m_start[i] = e;
            m_free[i]  = e + AC + 2;
            m_we[i]    = we[w];
            m_addr[i]  = addr[w];
            m_wdata[i] = wdata[w];
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!reset) model_reset();
            else        model_edge(i, cyc);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            string nm;
            int    n;
            logic  act, en, dn;
            logic [1:0] g;
            nm  = (i == 0) ? "rr" : "fx";
            n   = cyc;
            act = (n >= m_start[i]) && (n <= m_start[i] + AC);
            en  = (n >= m_start[i]) && (n <= m_start[i] + AC - 1);
            dn  = (n == m_start[i] + AC);
            g   = act ? ((m_owner[i] == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("%s.gnt", nm),       o_gnt[i],   g);
            chk($sformatf("%s.busy", nm),      o_busy[i],  act);
            chk($sformatf("%s.mem_en", nm),    o_en[i],    en);
            chk($sformatf("%s.mem_we", nm),    o_we[i],    en & m_we[i]);
            chk($sformatf("%s.mem_addr", nm),  o_addr[i],  m_addr[i]);
            chk($sformatf("%s.mem_wdata", nm), o_wdata[i], m_wdata[i]);
            chk($sformatf("%s.rdata", nm),     o_rdata[i], m_rdata[i]);
            chk($sformatf("%s.r0_done", nm),   o_d0[i],    dn && (m_owner[i] == 0));
            chk($sformatf("%s.r1_done", nm),   o_d1[i],    dn && (m_owner[i] == 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int p, input int inst, input string tag,
                             output int ticks, output int en_c, output int we_c);
        logic found;
        found = 1'b0;
        ticks = 0;
        en_c  = 0;
        we_c  = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            ticks++;
            if (o_en[inst]) en_c++;
            if (o_en[inst] && o_we[inst]) we_c++;
            if (p == 1 ? o_d1[inst] : o_d0[inst]) found = 1'b1;
        end
        chk($sformatf("%s.done_seen", tag), found, 1'b1);
    endtask

    initial begin
        int t, e, w, extra, fx1;
        int ord[$];
        int tstamp[$];
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
        end
        mem_rdata = '0;
        model_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) tick();
        chk("rst.busy", o_busy[0], 1'b0);
        chk("rst.gnt", o_gnt[0], 2'b00);
        chk("rst.rdata", o_rdata[0], 32'h0);
        @(posedge clk);
        #3 reset = 1'b1;
        tick();

        // T1 load
        mem_rdata = 32'hDEADBEEF;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40;
        wait_done(0, 0, "t1", t, e, w);
        req[0] = 1'b0;
        chk("t1.latency", t, 7);
        chk("t1.en_cycles", e, AC);
        chk("t1.rdata", o_rdata[0], 32'hDEADBEEF);
        tick();

        // T2 store
        mem_rdata = 32'h0BADF00D;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h10; wdata[1] = 32'h1234;
        wait_done(1, 0, "t2", t, e, w);
        req[1] = 1'b0;
        chk("t2.latency", t, 7);
        chk("t2.we_cycles", w, AC);
        chk("t2.rdata_kept", o_rdata[0], 32'hDEADBEEF);
        tick();

        // T3 round-robin with both ports requesting continuously
        we[0] = 1'b0; addr[0] = 32'h100; we[1] = 1'b1; addr[1] = 32'h200; wdata[1] = 32'h55;
        req[0] = 1'b1; req[1] = 1'b1;
        fx1 = 0;
        for (int k = 1; k <= 60 && ord.size() < 4; k++) begin
            tick();
            if (o_d1[1]) fx1++;
            if (o_d0[0]) begin ord.push_back(0); tstamp.push_back(k); end
            if (o_d1[0]) begin ord.push_back(1); tstamp.push_back(k); end
        end
        req[0] = 1'b0; req[1] = 1'b0;
        chk("t3.count", ord.size(), 4);
        for (int k = 0; k < ord.size(); k++) begin
            chk($sformatf("t3.order%0d", k), ord[k], k % 2);
            if (k > 0) chk($sformatf("t3.spacing%0d", k), tstamp[k] - tstamp[k-1], AC + 2);
        end
        chk("t4.fx_port1_starved", fx1, 0);
        repeat (3) tick();

        // T4 fixed priority: each port drops after its own done
        ord.delete();
        req[0] = 1'b1; req[1] = 1'b1;
        for (int k = 0; k < 60 && ord.size() < 2; k++) begin
            tick();
            if (o_d0[1]) begin ord.push_back(0); req[0] = 1'b0; end
            if (o_d1[1]) begin ord.push_back(1); req[1] = 1'b0; end
        end
        req[0] = 1'b0; req[1] = 1'b0;
        chk("t4.count", ord.size(), 2);
        if (ord.size() == 2) begin
            chk("t4.first", ord[0], 0);
            chk("t4.second", ord[1], 1);
        end
        repeat (3) tick();

        // T5 async reset mid-access, then a fresh access
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h44;
        repeat (3) tick();
        chk("t5.pre_en", o_en[0], 1'b1);
        #3 reset = 1'b0;
        model_reset();
        #1;
        chk("t5.async_en", o_en[0], 1'b0);
        chk("t5.async_busy", o_busy[0], 1'b0);
        chk("t5.async_gnt", o_gnt[0], 2'b00);
        chk("t5.async_addr", o_addr[0], 32'h0);
        chk("t5.async_rdata", o_rdata[0], 32'h0);
        repeat (2) tick();
        #3 reset = 1'b1;
        mem_rdata = 32'hCAFE0001;
        wait_done(0, 0, "t5", t, e, w);
        req[0] = 1'b0;
        chk("t5.latency", t, 7);
        chk("t5.rdata", o_rdata[0], 32'hCAFE0001);
        tick();

        // T6 address change and req drop mid-access
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40;
        repeat (2) tick();
        addr[0] = 32'h80; req[0] = 1'b0;
        tick();
        chk("t6.addr_latched", o_addr[0], 32'h40);
        wait_done(0, 0, "t6", t, e, w);
        chk("t6.latency", t + 3, 7);
        extra = 0;
        repeat (4) begin
            tick();
            if (o_d0[0]) extra++;
        end
        chk("t6.single_done", extra, 0);
        chk("t6.idle", o_busy[0], 1'b0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            mem_rdata = $urandom;
            for (int p = 0; p < 2; p++) begin
                logic dn;
                int   r;
                dn = (p == 1) ? o_d1[0] : o_d0[0];
                if (dn) begin
                    req[p] = 1'b0;
                end else if (!req[p]) begin
                    if ($urandom_range(3) == 0) begin
                        req[p] = 1'b1; we[p] = 1'($urandom_range(1));
                        addr[p] = $urandom; wdata[p] = $urandom;
                    end
                end else begin
                    r = $urandom_range(31);
                    if (r < 2)       addr[p]  = $urandom;
                    else if (r == 2) wdata[p] = $urandom;
                    else if (r == 3) we[p]    = ~we[p];
                    else if (r == 4) req[p]   = 1'b0;
                end
            end
            if (c == 1500) begin
                #2 reset = 1'b0;
                model_reset();
                tick();
                #2 reset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
